// File: rtl/eth_pipe_pkg.sv
// Shared Ethernet <-> AHIR pipe word layout, used by both rx and tx blocks.
// Word = {tlast, tdata, tkeep}; an all-zero tkeep on a tlast word marks a bad frame.
package eth_pipe_pkg;
  localparam int DATA_W   = 32;
  localparam int KEEP_W   = DATA_W / 8;
  localparam int WORD_W   = DATA_W + KEEP_W + 1;

  localparam int LAST_BIT = WORD_W - 1;
  localparam int DATA_MSB = WORD_W - 2;
  localparam int DATA_LSB = KEEP_W;
  localparam int KEEP_MSB = KEEP_W - 1;
  localparam int KEEP_LSB = 0;

  localparam int CNT_W    = 16;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth and a DEPTH+1 valued occupancy count.
module sync_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q + AW'(push_ok);
    rd_d  = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  // Storage is not reset; a slot is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rx_axis_to_pipe.sv
// MAC receive AXI-stream to AHIR pipe bridge: packs beats into pipe words,
// marks bad frames by zeroing tkeep on the last word, and counts frames.
module rx_axis_to_pipe
  import eth_pipe_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int S     = KEEP_W,
  parameter int D     = N + S + 1,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N-1:0]     rx_axis_tdata,
  input  logic [S-1:0]     rx_axis_tkeep,
  input  logic             rx_axis_tvalid,
  input  logic             rx_axis_tlast,
  input  logic             rx_axis_tuser,
  output logic             rx_axis_tready,
  output logic [D-1:0]     write_pipe_data,
  output logic             write_pipe_req,
  input  logic             write_pipe_ack,
  output logic [CNT_W-1:0] rx_frame_count,
  output logic [CNT_W-1:0] rx_bad_frame_count
);
  localparam int CW = $clog2(DEPTH);

  logic             full, empty, push, pop, bad_last;
  logic [CW:0]      occ;
  logic [S-1:0]     keep_w;
  logic [D-1:0]     word_in, word_out;
  logic             ready_q;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, bad_cnt_q, bad_cnt_d;

  // ready_q holds tready low through reset and rises on the first edge after release.
  assign rx_axis_tready  = ready_q & ~full;
  assign push            = rx_axis_tvalid & rx_axis_tready;
  assign write_pipe_req  = (occ != '0);
  assign pop             = write_pipe_req & write_pipe_ack;
  assign bad_last        = rx_axis_tlast & rx_axis_tuser;
  assign keep_w          = bad_last ? '0 : rx_axis_tkeep;
  assign word_in         = {rx_axis_tlast, rx_axis_tdata, keep_w};
  assign write_pipe_data = empty ? '0 : word_out;

  assign rx_frame_count     = frame_cnt_q;
  assign rx_bad_frame_count = bad_cnt_q;

  sync_fifo #(.W(D), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .din_i   (word_in),
    .pop_i   (pop),
    .dout_o  (word_out),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occ)
  );

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    if (push && rx_axis_tlast && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + 1'b1;
    if (push && bad_last && (bad_cnt_q != '1))        bad_cnt_d   = bad_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q     <= 1'b0;
      frame_cnt_q <= '0;
      bad_cnt_q   <= '0;
    end else begin
      ready_q     <= 1'b1;
      frame_cnt_q <= frame_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end
endmodule

// File: tb/tb_rx_axis_to_pipe.sv
// Scoreboard bench for rx_axis_to_pipe: table-driven frames plus backpressure,
// throughput, async reset and counter saturation sequences.
module tb_rx_axis_to_pipe;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast, tuser, tready;
  logic [36:0] pdata;
  logic        preq, pack;
  logic [15:0] fcnt, bcnt;

  always #5 clk = ~clk;

  rx_axis_to_pipe dut (
    .clk                (clk),
    .resetn             (resetn),
    .rx_axis_tdata      (tdata),
    .rx_axis_tkeep      (tkeep),
    .rx_axis_tvalid     (tvalid),
    .rx_axis_tlast      (tlast),
    .rx_axis_tuser      (tuser),
    .rx_axis_tready     (tready),
    .write_pipe_data    (pdata),
    .write_pipe_req     (preq),
    .write_pipe_ack     (pack),
    .rx_frame_count     (fcnt),
    .rx_bad_frame_count (bcnt)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
    logic [36:0] exp;
    logic        chk;
    logic [15:0] ef;
    logic [15:0] eb;
  } vec_t;

  logic [36:0] q[$];
  int errs = 0;
  int checks = 0;
  int stalls = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [36:0] model(input logic [31:0] d, input logic [3:0] k,
                                       input logic l, input logic u);
    return {l, d, (l & u) ? 4'h0 : k};
  endfunction

  // Holds the beat valid until accepted or max_wait cycles pass; returns at posedge+1.
  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l,
                       input logic u, input int max_wait, output logic ok);
    int w = 0;
    tdata = d; tkeep = k; tlast = l; tuser = u; tvalid = 1'b1;
    ok = 1'b0;
    while (!ok && w < max_wait) begin
      @(negedge clk);
      if (tready) ok = 1'b1;
      else stalls++;
      w++;
    end
    if (ok) q.push_back(model(d, k, l, u));
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    logic ok;
    drive(d, k, l, u, 50, ok);
    chk("beat_accepted", 64'(ok), 64'd1);
  endtask

  task automatic idle();
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_scoreboard_empty", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
    chk("drain_req_low", 64'(preq), 64'd0);
  endtask

  // Whenever a word is offered it must be the oldest expected one; pop on handshake.
  always @(negedge clk) begin
    if (resetn && preq) begin
      if (q.size() == 0) chk("spurious_word", 64'(pdata), 64'h1_0000_0000_0);
      else begin
        chk("pipe_word", 64'(pdata), 64'(q[0]));
        if (pack) void'(q.pop_front());
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: run did not complete, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic ok;

    tbl[0] = '{32'h11111111, 4'hF, 1'b0, 1'b0, {1'b0, 32'h11111111, 4'hF}, 1'b0, 16'd0, 16'd0};
    tbl[1] = '{32'h22222222, 4'hF, 1'b0, 1'b0, {1'b0, 32'h22222222, 4'hF}, 1'b0, 16'd0, 16'd0};
    tbl[2] = '{32'h33333333, 4'h3, 1'b1, 1'b0, {1'b1, 32'h33333333, 4'h3}, 1'b1, 16'd1, 16'd0};
    tbl[3] = '{32'h12345678, 4'hA, 1'b0, 1'b1, {1'b0, 32'h12345678, 4'hA}, 1'b0, 16'd0, 16'd0};
    tbl[4] = '{32'hDEADBEEF, 4'hF, 1'b1, 1'b1, {1'b1, 32'hDEADBEEF, 4'h0}, 1'b1, 16'd2, 16'd1};
    tbl[5] = '{32'hCAFEF00D, 4'h1, 1'b1, 1'b0, {1'b1, 32'hCAFEF00D, 4'h1}, 1'b1, 16'd3, 16'd1};

    resetn = 1'b0; tdata = '0; tkeep = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; pack = 1'b0;
    #3;
    chk("rst_req", 64'(preq), 64'd0);
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_data", 64'(pdata), 64'd0);
    chk("rst_fcnt", 64'(fcnt), 64'd0);
    chk("rst_bcnt", 64'(bcnt), 64'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    chk("tready_after_release", 64'(tready), 64'd1);

    // Table-driven frames: good, bad, and single-beat
    pack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("table_expect_model", 64'(model(tbl[i].d, tbl[i].k, tbl[i].l, tbl[i].u)), 64'(tbl[i].exp));
      send(tbl[i].d, tbl[i].k, tbl[i].l, tbl[i].u);
      if (tbl[i].chk) begin
        idle();
        drain();
        chk("table_fcnt", 64'(fcnt), 64'(tbl[i].ef));
        chk("table_bcnt", 64'(bcnt), 64'(tbl[i].eb));
      end
    end

    // Latency: word visible the cycle after acceptance into an empty buffer
    pack = 1'b0;
    send(32'hA5A5A5A5, 4'hC, 1'b1, 1'b0);
    idle();
    chk("latency_req", 64'(preq), 64'd1);
    pack = 1'b1;
    drain();

    // Backpressure: 16 fit, the 17th stalls, then everything drains in order
    pack = 1'b0; stalls = 0;
    for (int i = 0; i < 16; i++) send(32'h10000000 + i, 4'(i), 1'b0, 1'b0);
    chk("bp_no_stall_to_full", 64'(stalls), 64'd0);
    chk("bp_tready_full", 64'(tready), 64'd0);
    drive(32'h10000010, 4'h0, 1'b0, 1'b0, 3, ok);
    chk("bp_17th_refused", 64'(ok), 64'd0);
    chk("bp_scoreboard_16", 64'(q.size()), 64'd16);
    pack = 1'b1;
    for (int i = 16; i < 20; i++) send(32'h10000000 + i, 4'(i), (i == 19), 1'b0);
    idle();
    drain();
    chk("bp_fcnt", 64'(fcnt), 64'd5);

    // Throughput: back-to-back beats with ack high, occupancy stays at one
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      send(32'h20000000 + i, 4'hF, (i == 11), 1'b0);
      if (i > 0) begin
        chk("tput_req", 64'(preq), 64'd1);
        chk("tput_tready", 64'(tready), 64'd1);
      end
    end
    idle();
    chk("tput_no_stall", 64'(stalls), 64'd0);
    drain();

    // Async reset with 5 words buffered, then forward a frame remnant
    pack = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h30000000 + i, 4'hF, (i == 2), (i == 2));
    idle();
    #2 resetn = 1'b0;
    #1;
    chk("arst_req", 64'(preq), 64'd0);
    chk("arst_tready", 64'(tready), 64'd0);
    chk("arst_data", 64'(pdata), 64'd0);
    chk("arst_fcnt", 64'(fcnt), 64'd0);
    chk("arst_bcnt", 64'(bcnt), 64'd0);
    q.delete();
    #10 resetn = 1'b1;
    @(posedge clk); #1;
    chk("arst_tready_back", 64'(tready), 64'd1);
    chk("arst_empty", 64'(preq), 64'd0);
    pack = 1'b1;
    send(32'h40000000, 4'hF, 1'b0, 1'b0);
    send(32'h40000001, 4'h7, 1'b1, 1'b0);
    idle();
    drain();
    chk("remnant_fcnt", 64'(fcnt), 64'd1);

    // Saturation: bad single-beat frames drive both counters to the top
    begin
      int acc = 0;
      for (int i = 0; i < 16'hFFFD; i++) begin
        drive(32'(i), 4'hF, 1'b1, 1'b1, 50, ok);
        if (ok) acc++;
      end
      idle();
      chk("sat_preload_accepted", 64'(acc), 64'hFFFD);
    end
    chk("sat_fcnt_pre", 64'(fcnt), 64'hFFFE);
    chk("sat_bcnt_pre", 64'(bcnt), 64'hFFFD);
    for (int i = 0; i < 3; i++) send(32'h50000000 + i, 4'hF, 1'b1, 1'b1);
    idle();
    drain();
    chk("sat_fcnt", 64'(fcnt), 64'hFFFF);
    chk("sat_bcnt", 64'(bcnt), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
